hex_value_entry: RTL and testbench

Board-side hex entry block: turns the slide switches and push-buttons into a 24-bit value, one hex digit at a time, most-significant digit first. It is the input counterpart of the six-digit hex display path. Its live `entry` buffer and `cursor` feed the display so the user sees what is being typed. A committed value is handed to the rest of the design, such as the processor's memory-mapped I/O, over a valid/ready handshake.

---
 rtl/hex_entry_pkg.sv | 20 ++
 rtl/key_debounce.sv | 55 +++++
 rtl/hex_value_entry.sv | 87 ++++++++
 tb/tb_hex_value_entry.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_entry_pkg.sv
// Shared widths, reset constants and types for the
// switch/button hex entry block.
package hex_entry_pkg;

  localparam int DIGITS   = 6;
  localparam int NIBBLE_W = 4;
  localparam int ENTRY_W  = 24;
  localparam int OUT_W    = 32;

  typedef logic [2:0] cursor_t;

  localparam cursor_t CURSOR_RESET = 3'd5;

  typedef struct packed {
    logic load;
    logic commit;
    logic clear;
  } key_press_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizer, debounce counter and press-edge detect for one
// active-low push-button.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [1:0]    fill;
  logic          stable;
  logic          stable_d;
  logic          armed;
  logic          lvl;

  assign lvl = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= 2'b11;
      cnt      <= '0;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      fill     <= 2'd0;
      armed    <= 1'b0;
    end else begin
      sync     <= {sync[0], key_n};
      stable_d <= stable;
      if (lvl == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= lvl;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (fill != 2'd2)
        fill <= fill + 2'd1;
      // arm only once a real released level has been seen
      if (fill == 2'd2 && stable && lvl)
        armed <= 1'b1;
    end
  end

  assign press = armed & stable_d & ~stable;

endmodule

// File: rtl/hex_value_entry.sv
// Hex digit entry buffer with cursor and a valid/ready
// output register for committed values.
module hex_value_entry
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NIBBLE_W-1:0] sw,
  input  logic                key_load_n,
  input  logic                key_commit_n,
  input  logic                key_clear_n,
  output logic [ENTRY_W-1:0]  entry,
  output cursor_t             cursor,
  output logic [OUT_W-1:0]    out_val,
  output logic                out_valid,
  input  logic                out_ready
);

  key_press_t          press;
  logic [ENTRY_W-1:0]  entry_load;
  cursor_t             cursor_dec;
  logic                commit_ok;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_load_n),
    .press (press.load)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_commit_n),
    .press (press.commit)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_clear_n),
    .press (press.clear)
  );

  always_comb begin
    entry_load = entry;
    for (int i = 0; i < DIGITS; i++) begin
      if (cursor == cursor_t'(i))
        entry_load[i*NIBBLE_W +: NIBBLE_W] = sw;
    end
  end

  assign cursor_dec =
    (cursor == 3'd0) ? CURSOR_RESET : cursor - 3'd1;

  // a pending value blocks capture unless it leaves this cycle
  assign commit_ok =
    press.commit & (~out_valid | out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry  <= '0;
      cursor <= CURSOR_RESET;
    end else if (press.clear) begin
      entry  <= '0;
      cursor <= CURSOR_RESET;
    end else if (press.load) begin
      entry  <= entry_load;
      cursor <= cursor_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val   <= '0;
      out_valid <= 1'b0;
    end else if (commit_ok) begin
      out_val   <= {{(OUT_W-ENTRY_W){1'b0}}, entry};
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hex_value_entry.sv
// Randomized scoreboard bench for hex_value_entry with a
// digit-array reference model.
module tb_hex_value_entry;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw;
  logic        kl;
  logic        km;
  logic        kc;
  logic [23:0] entry;
  logic [2:0]  cursor;
  logic [31:0] out_val;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  hex_value_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .key_load_n   (kl),
    .key_commit_n (km),
    .key_clear_n  (kc),
    .entry        (entry),
    .cursor       (cursor),
    .out_val      (out_val),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  int          total = 0;
  int          bad   = 0;
  int          m_dig [6];
  int          m_cur;
  logic [31:0] m_val;
  bit          m_valid;
  logic [31:0] sbq [$];

  function automatic logic [23:0] m_entry();
    int v = 0;
    for (int i = 5; i >= 0; i--)
      v = v * 16 + m_dig[i];
    return v[23:0];
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".entry"}, {8'h0, entry}, {8'h0, m_entry()});
    chk({tag, ".cursor"}, {29'h0, cursor}, m_cur);
    chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, m_valid});
    chk({tag, ".val"}, out_val, m_val);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_dig[i] = 0;
    m_cur   = 5;
    m_val   = '0;
    m_valid = 1'b0;
    sbq.delete();
  endtask

  task automatic m_load(input logic [3:0] s);
    m_dig[m_cur] = int'(s);
    m_cur = (m_cur == 0) ? 5 : m_cur - 1;
  endtask

  task automatic m_apply(input bit ld, input bit cl, input bit cm,
                         input logic [3:0] s, input bit rdy);
    if (cm && (!m_valid || rdy)) begin
      m_val = {8'h0, m_entry()};
      sbq.push_back(m_val);
      m_valid = 1'b1;
    end
    if (rdy) m_valid = 1'b0;
    if (cl) begin
      for (int i = 0; i < 6; i++) m_dig[i] = 0;
      m_cur = 5;
    end else if (ld) begin
      m_load(s);
    end
  endtask

  task automatic do_press(input bit ld, input bit cl, input bit cm,
                          input logic [3:0] s, input bit rdy);
    m_apply(ld, cl, cm, s, rdy);
    @(negedge clk);
    sw = s;
    out_ready = rdy;
    kl = ~ld;
    kc = ~cl;
    km = ~cm;
    repeat (10) @(negedge clk);
    kl = 1'b1;
    kc = 1'b1;
    km = 1'b1;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
  endtask

  // monitor: each accepted value must match the oldest capture
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL accept: got %h expected none", out_val);
      end else begin
        chk("accept", out_val, sbq.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] nv;
    rst = 1'b1;
    sw = '0;
    kl = 1'b1;
    km = 1'b1;
    kc = 1'b1;
    out_ready = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset");

    for (int i = 1; i <= 6; i++)
      do_press(1'b1, 1'b0, 1'b0, 4'(i), 1'b0);
    chk("load6", {8'h0, entry}, 32'h00123456);
    chk("wrap", {29'h0, cursor}, 32'd5);
    do_press(1'b1, 1'b0, 1'b0, 4'hF, 1'b0);
    chk("load7", {8'h0, entry}, 32'h00F23456);
    check_state("load7");

    @(negedge clk);
    kl = 1'b0;
    repeat (3) @(negedge clk);
    kl = 1'b1;
    repeat (15) @(negedge clk);
    check_state("glitch");

    @(negedge clk);
    sw = 4'h7;
    kl = 1'b0;
    repeat (6) @(negedge clk);
    check_state("pre_edge");
    m_load(4'h7);
    @(negedge clk);
    check_state("post_edge");
    kl = 1'b1;
    repeat (12) @(negedge clk);

    do_press(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 10; i <= 15; i++)
      do_press(1'b1, 1'b0, 1'b0, 4'(i), 1'b0);
    do_press(1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    chk("commit", out_val, 32'h00ABCDEF);
    check_state("commit");
    do_press(1'b1, 1'b0, 1'b0, 4'h1, 1'b0);
    do_press(1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    chk("dropped", out_val, 32'h00ABCDEF);
    drain();
    check_state("drain");

    do_press(1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    do_press(1'b1, 1'b0, 1'b0, 4'h2, 1'b0);
    nv = {8'h0, m_entry()};
    @(negedge clk);
    km = 1'b0;
    repeat (6) @(negedge clk);
    out_ready = 1'b1;
    sbq.push_back(nv);
    m_val = nv;
    m_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    km = 1'b1;
    repeat (12) @(negedge clk);
    chk("b2b_valid", {31'h0, out_valid}, 32'd1);
    chk("b2b_val", out_val, 32'h0012CDEF);
    drain();

    do_press(1'b1, 1'b1, 1'b0, 4'h9, 1'b0);
    check_state("ld_clr");
    do_press(1'b1, 1'b0, 1'b0, 4'h5, 1'b0);
    do_press(1'b1, 1'b0, 1'b1, 4'h3, 1'b0);
    chk("ld_cmt", out_val, 32'h00500000);
    check_state("ld_cmt");

    @(negedge clk);
    kl = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_reset();
    #1;
    check_state("rst_now");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_state("held");
    kl = 1'b1;
    repeat (15) @(negedge clk);
    check_state("released");
    do_press(1'b1, 1'b0, 1'b0, 4'h9, 1'b0);
    check_state("repress");

    for (int n = 0; n < 30; n++) begin
      logic [3:0] s;
      int op;
      s = 4'($urandom_range(0, 15));
      op = $urandom_range(0, 6);
      case (op)
        0, 1: do_press(1'b1, 1'b0, 1'b0, s, 1'b0);
        2: do_press(1'b0, 1'b1, 1'b0, s, 1'b0);
        3: do_press(1'b0, 1'b0, 1'b1, s, 1'b0);
        4: do_press(1'b0, 1'b0, 1'b1, s, 1'b1);
        5: drain();
        default: do_press(1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), s,
                          1'($urandom_range(0, 1)));
      endcase
      check_state("rand");
    end

    drain();
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
